// File: rtl/piece_sequencer_if.sv
// rtl/piece_sequencer_if.sv - piece handshake and preview bus between sequencer and game FSM
interface piece_sequencer_if;
    logic       start;
    logic       piece_ready;
    logic       piece_valid;
    logic [2:0] piece;
    logic [2:0] preview;
    logic       preview_valid;
    logic [2:0] fill_count;

    modport master (
        output start,
        output piece_ready,
        input  piece_valid,
        input  piece,
        input  preview,
        input  preview_valid,
        input  fill_count
    );

    modport slave (
        input  start,
        input  piece_ready,
        output piece_valid,
        output piece,
        output preview,
        output preview_valid,
        output fill_count
    );
endinterface

// File: rtl/piece_sequencer.sv
// rtl/piece_sequencer.sv - tetromino scheduler: seeded LFSR, repeat/bag filter, preview FIFO (optional SEVEN_BAG_EN)
module piece_sequencer #(
    parameter int DEPTH      = 3,
    parameter int MAX_REROLL = 1,
    parameter int NUM_PIECES = 7
) (
    input  logic             clock,
    input  logic             resetn,
    piece_sequencer_if.slave bus
);

    localparam logic [1:0] ST_UNSEEDED = 2'd0;
    localparam logic [1:0] ST_FILL     = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [2:0] DEPTH_L     = 3'(DEPTH);

    logic [1:0] r_state;
    logic [7:0] r_seed_cnt;
    logic [7:0] r_lfsr;
    logic [2:0] r_fill;
    logic [2:0] r_fifo [DEPTH];

    logic [7:0] w_lfsr_next;
    logic [2:0] w_cand;
    logic       w_valid;
    logic       w_pop;
    logic       w_gen;
    logic       w_discard;
    logic       w_push;
    logic [2:0] w_wr_idx;
    logic [2:0] w_fill_next;
    logic [2:0] w_fifo_next [DEPTH];

    assign w_lfsr_next = {r_lfsr[0],
                          r_lfsr[7] ^ r_lfsr[0],
                          r_lfsr[6] ^ r_lfsr[0],
                          r_lfsr[5],
                          r_lfsr[4],
                          r_lfsr[3] ^ r_lfsr[0],
                          r_lfsr[2],
                          r_lfsr[1]};
    assign w_cand = 3'(w_lfsr_next % 8'(NUM_PIECES));

    // start overrides both pop and generation in its cycle
    assign w_valid = (r_state == ST_RUN) && (r_fill != 3'd0);
    assign w_pop   = w_valid && bus.piece_ready && !bus.start;
    assign w_gen   = !bus.start &&
                     ((r_state == ST_FILL) ||
                      ((r_state == ST_RUN) && ((r_fill < DEPTH_L) || w_pop)));
    assign w_push  = w_gen && !w_discard;

    assign w_wr_idx    = w_pop ? (r_fill - 3'd1) : r_fill;
    assign w_fill_next = r_fill + {2'b00, w_push} - {2'b00, w_pop};

`ifdef SEVEN_BAG_EN
    logic [6:0] r_mask;
    logic [6:0] w_mask_set;

    assign w_discard  = r_mask[w_cand];
    assign w_mask_set = r_mask | (7'd1 << w_cand);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_mask <= 7'd0;
        end else if (bus.start) begin
            r_mask <= 7'd0;
        end else if (w_push) begin
            r_mask <= (&w_mask_set) ? 7'd0 : w_mask_set;
        end
    end
`else
    localparam logic [2:0] MAX_L = 3'(MAX_REROLL);

    logic [2:0] r_last;
    logic [2:0] r_reroll;

    assign w_discard = (w_cand == r_last) && (r_reroll < MAX_L);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_last   <= 3'd7;
            r_reroll <= 3'd0;
        end else if (bus.start) begin
            r_last   <= 3'd7;
            r_reroll <= 3'd0;
        end else if (w_gen) begin
            if (w_discard) begin
                r_reroll <= r_reroll + 3'd1;
            end else begin
                r_last   <= w_cand;
                r_reroll <= 3'd0;
            end
        end
    end
`endif

    // head lives in entry 0; a pop shifts everything down before the push lands
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_fifo_next[i] = r_fifo[i];
        end
        if (w_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_fifo_next[i] = r_fifo[i + 1];
            end
            w_fifo_next[DEPTH - 1] = 3'd0;
        end
        if (w_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (3'(i) == w_wr_idx) begin
                    w_fifo_next[i] = w_cand;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_UNSEEDED;
            r_seed_cnt <= 8'h00;
            r_lfsr     <= 8'h01;
            r_fill     <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo[i] <= 3'd0;
            end
        end else begin
            r_seed_cnt <= r_seed_cnt + 8'd1;
            if (bus.start) begin
                r_lfsr  <= (r_seed_cnt == 8'h00) ? 8'h01 : r_seed_cnt;
                r_fill  <= 3'd0;
                r_state <= ST_FILL;
            end else begin
                if (w_gen) begin
                    r_lfsr <= w_lfsr_next;
                end
                r_fill <= w_fill_next;
                for (int i = 0; i < DEPTH; i++) begin
                    r_fifo[i] <= w_fifo_next[i];
                end
                if ((r_state == ST_FILL) && (w_fill_next == DEPTH_L)) begin
                    r_state <= ST_RUN;
                end
            end
        end
    end

    assign bus.piece_valid   = w_valid;
    assign bus.piece         = w_valid ? r_fifo[0] : 3'd0;
    assign bus.preview_valid = w_valid && (r_fill >= 3'd2);
    assign bus.preview       = (w_valid && (r_fill >= 3'd2)) ? r_fifo[1] : 3'd0;
    assign bus.fill_count    = r_fill;

endmodule
